mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-clock, parametrised successor to the core's clock-phase-multiplexed unified memory: one single-ported, byte-addressable instruction/data memory shared by the IF stage (fetch port) and the MEM stage (data port). It arbitrates per cycle with a starvation guard, executes RV32 load/store sizing (LB/LH/LW/LBU/LHU, SB/SH/SW), and returns read data with fixed one-cycle latency. The pipeline uses the deasserted grant outputs as its stall signals.

## Interface
- DEPTH_BYTES, 4096: memory size in bytes; power of two, ≥ 64.
- ADDR_W, 12: byte-address width used; must equal log2(DEPTH_BYTES).
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced through; range 1–15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  32  fetched instruction word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_f3  in  3  RV32 funct3 size/sign code.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_rvalid  out  1  load data valid.
- d_rdata  out  32  load data, sized and extended.
- d_err  out  1  misaligned-access flag (only with MEM_MISALIGN_TRAP_EN; tied 0 otherwise).

## Operation
- At most one access per cycle. An access is accepted at a rising edge where req & gnt.
- Priority: the data port wins, except when if_req=1 and starve_cnt==STARVE_MAX; then the fetch wins and d_gnt=0.
- starve_cnt (4 bits): +1 on each data grant while if_req=1, saturating at STARVE_MAX; cleared on any fetch grant or any cycle with if_req=0.
- Addresses are wrapped modulo DEPTH_BYTES, so bits [31:ADDR_W] are ignored. Fetch always reads a word and ignores if_addr[1:0].
- Load sizing:
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 100 LBU / 101 LHU: zero-extended.
  - 010, 011, 110, 111: full word.
- Store sizing:
  - 000 SB: byte lane d_addr[1:0].
  - 001 SH: half lane d_addr[1].
  - All other codes: full word.
  - Only the enabled lanes are written.
- Stores produce no d_rvalid.
- Memory contents are not reset.

## Timing
- Grants are combinational in the request cycle.
- Read latency is exactly 1 cycle: rvalid=1 in the cycle after the accepting edge, for one cycle. rdata is registered and holds until the next read response.
- A store is committed at its accepting edge. A load of the same address accepted at the next edge returns the new data.
- Back-to-back accepted reads give rvalid on consecutive cycles.
- Reset values: if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, d_err=0, starve_cnt=0. Both grants follow the combinational rule even during reset.
- While rst=1, no store commits, and no response from a pre-reset acceptance appears after reset.
- If both ports are idle, nothing changes except starve_cnt clearing.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A data access is misaligned if d_f3[1:0]==01 with d_addr[0]=1, or d_f3[1:0]==10/11 with d_addr[1:0]≠0.
  - A misaligned access is still granted. It writes nothing.
  - One cycle later: d_err=1 for one cycle; for loads also d_rvalid=1 with d_rdata=0.
- Undefined:
  - Misaligned addresses are silently aligned down to the access size.
  - d_err is constant 0.

## Test plan
- Word round-trip: store SW 0xDEADBEEF at 0x40, then LW 0x40 → d_rvalid one cycle after grant, d_rdata=0xDEADBEEF.
- Sub-word:
  - After the word above, SB 0x7F at 0x41 → LW 0x40 = 0xDEAD7FEF.
  - LB 0x43 = 0xFFFFFFDE.
  - LHU 0x42 = 0x0000DEAD.
- Arbitration with STARVE_MAX=4: if_req and d_req held high → d_gnt 4 cycles, if_gnt 1 cycle, repeating. Fetch never starved beyond 4 cycles.
- Wrap: SW 0x12345678 to DEPTH_BYTES+0x10 → fetch at 0x10 returns 0x12345678.
- Reset mid-read: assert rst in the cycle after a load is granted → d_rvalid=0, d_rdata=0, starve_cnt=0 on the following cycle.
- Misalign:
  - With the macro: LW at 0x42 → d_err=1 and d_rdata=0 one cycle later; SH at 0x45 leaves memory unchanged.
  - Without the macro: LW at 0x42 returns the word at 0x40.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-ported, byte-addressable memory shared by the
// instruction-fetch port and the data port. Only one access is accepted per
// cycle. The data port normally wins. A starvation counter forces a pending
// fetch through after STARVE_MAX consecutive data grants.
//
// Handshake (both ports): an access is accepted on a rising edge where
// req && gnt. Grants are combinational from the current request inputs. The
// pipeline treats a deasserted grant as its stall. For every accepted read,
// rvalid is high for exactly one cycle after the accepting edge. rdata is
// registered and holds its value until the next read response. Stores
// produce no rvalid.
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned data
// accesses on d_err. A flagged access writes nothing, and a flagged load
// returns zero. Without the macro, misaligned addresses are aligned down
// to the access size, and d_err is tied to 0.
module mem_port_arbiter #(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 12,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_f3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err
);

  localparam int         WORDS      = DEPTH_BYTES / 4;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [31:0]       mem [WORDS];
  logic [3:0]        starve_cnt;
  logic              fetch_force;
  logic [ADDR_W-3:0] if_widx;
  logic [ADDR_W-3:0] d_widx;
  logic [31:0]       d_word;
  logic [7:0]        d_byte;
  logic [15:0]       d_half;
  logic [31:0]       load_data;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              unused_addr_bits;

  // Bits above the memory size are ignored. A fetch always reads a whole word.
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[1:0], d_addr[31:ADDR_W]};

  assign if_widx = if_addr[ADDR_W-1:2];
  assign d_widx  = d_addr[ADDR_W-1:2];

  // The data port wins unless a pending fetch has waited STARVE_MAX data grants.
  assign fetch_force = if_req && (starve_cnt == STARVE_LIM);
  assign d_gnt       = d_req && !fetch_force;
  assign if_gnt      = if_req && !d_gnt;

`ifdef MEM_MISALIGN_TRAP_EN
  logic d_mis;
  assign d_mis = ((d_f3[1:0] == 2'b01) && d_addr[0]) ||
                 (d_f3[1] && (d_addr[1:0] != 2'b00));
`endif

  assign d_word = mem[d_widx];
  assign d_byte = d_word[{d_addr[1:0], 3'b000} +: 8];
  assign d_half = d_addr[1] ? d_word[31:16] : d_word[15:0];

  // Load sizing and extension, chosen from the full funct3 code.
  always_comb begin
    load_data = d_word;
    case (d_f3)
      3'b000:  load_data = {{24{d_byte[7]}}, d_byte};
      3'b001:  load_data = {{16{d_half[15]}}, d_half};
      3'b100:  load_data = {24'h0, d_byte};
      3'b101:  load_data = {16'h0, d_half};
      default: load_data = d_word;
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    if (d_mis) load_data = 32'h0;
`endif
  end

  // Store lane enables. Right-aligned store data is replicated into every lane.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = d_wdata;
    case (d_f3)
      3'b000: begin
        wr_be   = 4'b0001 << d_addr[1:0];
        wr_data = {4{d_wdata[7:0]}};
      end
      3'b001: begin
        wr_be   = d_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{d_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = d_wdata;
      end
    endcase
`ifdef MEM_MISALIGN_TRAP_EN
    if (d_mis) wr_be = 4'b0000;
`endif
  end

  // Store commit at the accepting edge. Memory contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && d_gnt && d_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[d_widx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Starvation counter: counts data grants that a pending fetch has lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= 4'd0;
    end else if (d_gnt && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // One-cycle read responses. Reset discards any response still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'h0;
      d_rvalid  <= 1'b0;
      d_rdata   <= 32'h0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) if_rdata <= mem[if_widx];
      d_rvalid <= d_gnt && !d_we;
      if (d_gnt && !d_we) d_rdata <= load_data;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misalignment flag, raised for one cycle after the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) d_err <= 1'b0;
    else     d_err <= d_gnt && d_mis;
  end
`else
  assign d_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Driver tasks push the expected
// responses into queues. A monitor running on the falling edge pops and
// compares each response whenever the DUT raises rvalid. The bench also
// builds with MEM_MISALIGN_TRAP_EN defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_f3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  mem_port_arbiter #(.DEPTH_BYTES(4096), .ADDR_W(12), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_f3(d_f3), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] if_exp_q[$];
  int          if_cyc_q[$];
  int          err_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        flag("d response missing");
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      if (if_cyc_q.size() > 0 && if_cyc_q[0] < cyc) begin
        flag("if response missing");
        void'(if_exp_q.pop_front());
        void'(if_cyc_q.pop_front());
      end
      if (d_rvalid) begin
        if (exp_q.size() == 0) flag("d_rvalid unexpected");
        else begin
          check("d_rdata", d_rdata, exp_q.pop_front());
          check("d_rvalid cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end
      if (if_rvalid) begin
        if (if_exp_q.size() == 0) flag("if_rvalid unexpected");
        else begin
          check("if_rdata", if_rdata, if_exp_q.pop_front());
          check("if_rvalid cycle", 32'(cyc), 32'(if_cyc_q.pop_front()));
        end
      end
      begin
        bit exp_err;
        exp_err = (err_cyc_q.size() > 0) && (err_cyc_q[0] == cyc);
        if (exp_err) void'(err_cyc_q.pop_front());
        check("d_err", 32'(d_err), 32'(exp_err));
      end
    end
  end

  // Driver: one data access; waits a bounded time for the grant.
  task automatic d_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit resp,
                      input logic [31:0] exp_data, input bit exp_err);
    int n = 0;
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_f3 = f3; d_addr = addr; d_wdata = wdata;
    #1;
    while (!d_gnt && n < 8) begin @(negedge clk); #1; n++; end
    checks++;
    if (!d_gnt) begin
      errors++;
      $display("FAIL d_gnt timeout addr %h got 0 expected 1", addr);
    end else begin
      if (resp) begin exp_q.push_back(exp_data); exp_cyc_q.push_back(cyc + 1); end
      if (exp_err) err_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  // Driver: one fetch.
  task automatic f_op(input logic [31:0] addr, input logic [31:0] exp_data);
    int n = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    #1;
    while (!if_gnt && n < 8) begin @(negedge clk); #1; n++; end
    checks++;
    if (!if_gnt) begin
      errors++;
      $display("FAIL if_gnt timeout addr %h got 0 expected 1", addr);
    end else begin
      if_exp_q.push_back(exp_data); if_cyc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  // Both ports requesting: with STARVE_MAX=4 the grant pattern is D,D,D,D,F repeating.
  task automatic arb_run(input int n, input logic [31:0] d_word, input logic [31:0] f_word);
    for (int k = 0; k < n; k++) begin
      bit exp_f;
      @(negedge clk);
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_f3 = 3'b010; d_addr = 32'h40;
      #1;
      exp_f = (k % 5) == 4;
      check($sformatf("arb if_gnt k=%0d", k), 32'(if_gnt), 32'(exp_f));
      check($sformatf("arb d_gnt k=%0d", k), 32'(d_gnt), 32'(!exp_f));
      if (exp_f) begin if_exp_q.push_back(f_word); if_cyc_q.push_back(cyc + 1); end
      else begin exp_q.push_back(d_word); exp_cyc_q.push_back(cyc + 1); end
    end
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_f3 = 3'b010; d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset d_rvalid", 32'(d_rvalid), 32'h0);
    check("reset if_rvalid", 32'(if_rvalid), 32'h0);
    check("reset d_rdata", d_rdata, 32'h0);
    check("reset if_rdata", if_rdata, 32'h0);
    check("reset d_err", 32'(d_err), 32'h0);
    mon_en = 1'b1;

    // Word round trip and sub-word accesses
    d_op(1, 3'b010, 32'h40, 32'hDEADBEEF, 0, 32'h0, 0);
    d_op(0, 3'b010, 32'h40, 32'h0, 1, 32'hDEADBEEF, 0);
    d_op(1, 3'b000, 32'h41, 32'hAABBCC7F, 0, 32'h0, 0);
    d_op(0, 3'b010, 32'h40, 32'h0, 1, 32'hDEAD7FEF, 0);
    d_op(0, 3'b000, 32'h43, 32'h0, 1, 32'hFFFFFFDE, 0);
    d_op(0, 3'b101, 32'h42, 32'h0, 1, 32'h0000DEAD, 0);
    d_op(0, 3'b001, 32'h42, 32'h0, 1, 32'hFFFFDEAD, 0);
    d_op(0, 3'b100, 32'h41, 32'h0, 1, 32'h0000007F, 0);
    d_op(0, 3'b001, 32'h40, 32'h0, 1, 32'h00007FEF, 0);
    d_op(1, 3'b001, 32'h42, 32'h1234A5A5, 0, 32'h0, 0);
    d_op(0, 3'b010, 32'h40, 32'h0, 1, 32'hA5A57FEF, 0);

    // Address wrap; a store in between leaves d_rdata holding its value
    d_op(1, 3'b010, 32'h1010, 32'h12345678, 0, 32'h0, 0);
    check("d_rdata hold", d_rdata, 32'hA5A57FEF);
    f_op(32'h10, 32'h12345678);
    f_op(32'h13, 32'h12345678);
    d_op(0, 3'b010, 32'hFFFFF010, 32'h0, 1, 32'h12345678, 0);

    // Misaligned accesses
    d_op(1, 3'b010, 32'h44, 32'h0, 0, 32'h0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    d_op(0, 3'b010, 32'h42, 32'h0, 1, 32'h0, 1);
    d_op(1, 3'b001, 32'h45, 32'h0000FFFF, 0, 32'h0, 1);
    d_op(0, 3'b010, 32'h44, 32'h0, 1, 32'h0, 0);
    d_op(0, 3'b001, 32'h41, 32'h0, 1, 32'h0, 1);
`else
    d_op(0, 3'b010, 32'h42, 32'h0, 1, 32'hA5A57FEF, 0);
    d_op(1, 3'b001, 32'h45, 32'h0000FFFF, 0, 32'h0, 0);
    d_op(0, 3'b010, 32'h44, 32'h0, 1, 32'h0000FFFF, 0);
    d_op(0, 3'b001, 32'h41, 32'h0, 1, 32'h00007FEF, 0);
`endif

    // Arbitration with starvation guard
    arb_run(15, 32'hA5A57FEF, 32'h12345678);

    // Reset in the cycle after a load grant; a store issued during reset must not commit
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_f3 = 3'b010; d_addr = 32'h40;
    #1;
    check("pre-reset d_gnt", 32'(d_gnt), 32'h1);
    exp_q.push_back(32'hA5A57FEF); exp_cyc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    rst = 1'b1; d_we = 1'b1; d_wdata = 32'h0;
    check("d_gnt during reset", 32'(d_gnt), 32'h1);
    check("if_gnt during reset", 32'(if_gnt), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
    check("post-reset d_rvalid", 32'(d_rvalid), 32'h0);
    check("post-reset d_rdata", d_rdata, 32'h0);
    check("post-reset if_rvalid", 32'(if_rvalid), 32'h0);
    check("post-reset starve_cnt", 32'(dut.starve_cnt), 32'h0);
    d_op(0, 3'b010, 32'h40, 32'h0, 1, 32'hA5A57FEF, 0);
    arb_run(10, 32'hA5A57FEF, 32'h12345678);

    repeat (3) @(negedge clk);
    check("d queue drained", 32'(exp_q.size()), 32'h0);
    check("if queue drained", 32'(if_exp_q.size()), 32'h0);
    check("err queue drained", 32'(err_cyc_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
